// File: rtl/dram_pkg.sv
// Shared types and helpers for the data-side memory controller:
// address regions, timer register offsets and the byte-lane merge.
package dram_pkg;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_TIMER,
    REGION_UNMAPPED
  } region_t;

  localparam logic [3:0] TMR_MTIME_LO    = 4'h0;
  localparam logic [3:0] TMR_MTIME_HI    = 4'h4;
  localparam logic [3:0] TMR_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] TMR_MTIMECMP_HI = 4'hC;

  // Lanes with their enable set take the new byte, the rest keep the old one.
  function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  byteEn);
    logic [31:0] result;
    result = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) result[8*i +: 8] = newWord[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/dram_ctl_if.sv
// Read/write request bus between the core's data port and the controller,
// plus the controller's status outputs.
interface dram_ctl_if #(parameter int XLEN = 32) ();

  logic            rd_en_i;
  logic [XLEN-1:0] rd_addr_i;
  logic            wr_en_i;
  logic [XLEN-1:0] wr_addr_i;
  logic [XLEN-1:0] wr_data_i;
  logic [3:0]      wr_byte_en_i;
  logic [XLEN-1:0] rd_data_o;
  logic            rd_valid_o;
  logic            err_o;
  logic            timer_irq_o;

  modport master (
    output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_byte_en_i,
    input  rd_data_o, rd_valid_o, err_o, timer_irq_o
  );

  modport slave (
    input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_byte_en_i,
    output rd_data_o, rd_valid_o, err_o, timer_irq_o
  );

endinterface

// File: rtl/dram_timer.sv
// 64-bit machine timer: free-running mtime, mtimecmp, lane writes,
// registered compare interrupt and a combinational read mux.
module dram_timer
  import dram_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_wrEn,
  input  logic [3:0]  i_wrOff,
  input  logic [31:0] i_wrData,
  input  logic [3:0]  i_wrByteEn,
  input  logic [3:0]  i_rdOff,
  output logic [31:0] o_rdData,
  output logic        o_irq
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_irq;

  // A write to either mtime half takes the place of that cycle's increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= (r_mtime >= r_mtimecmp);
      if (i_wrEn && i_wrOff == TMR_MTIME_LO)
        r_mtime[31:0] <= mergeLanes(r_mtime[31:0], i_wrData, i_wrByteEn);
      else if (i_wrEn && i_wrOff == TMR_MTIME_HI)
        r_mtime[63:32] <= mergeLanes(r_mtime[63:32], i_wrData, i_wrByteEn);
      else
        r_mtime <= r_mtime + 64'd1;
      if (i_wrEn && i_wrOff == TMR_MTIMECMP_LO)
        r_mtimecmp[31:0] <= mergeLanes(r_mtimecmp[31:0], i_wrData, i_wrByteEn);
      if (i_wrEn && i_wrOff == TMR_MTIMECMP_HI)
        r_mtimecmp[63:32] <= mergeLanes(r_mtimecmp[63:32], i_wrData, i_wrByteEn);
    end
  end

  always_comb begin
    o_rdData = '0;
    case (i_rdOff)
      TMR_MTIME_LO:    o_rdData = r_mtime[31:0];
      TMR_MTIME_HI:    o_rdData = r_mtime[63:32];
      TMR_MTIMECMP_LO: o_rdData = r_mtimecmp[31:0];
      TMR_MTIMECMP_HI: o_rdData = r_mtimecmp[63:32];
      default:         o_rdData = '0;
    endcase
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/dram_ctl.sv
// Data-side memory controller: decodes core accesses to RAM, timer or
// unmapped space, returns registered read data and flags unmapped hits.
module dram_ctl
  import dram_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 1024,
  parameter logic [XLEN-1:0] TIMER_BASE = 32'h0200_0000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  dram_ctl_if.slave  bus
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [XLEN-1:0] RAM_LIMIT = XLEN'(DEPTH * 4);

  function automatic region_t decodeRegion(input logic [XLEN-1:0] addr);
    if (addr < RAM_LIMIT)
      return REGION_RAM;
    else if (addr[XLEN-1:4] == TIMER_BASE[XLEN-1:4])
      return REGION_TIMER;
    else
      return REGION_UNMAPPED;
  endfunction

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdData;
  logic            r_rdValid;
  logic            r_err;

  region_t         w_rdRegion;
  region_t         w_wrRegion;
  logic            w_rdActive;
  logic            w_wrActive;
  logic [AW-1:0]   w_rdIdx;
  logic [AW-1:0]   w_wrIdx;
  logic [XLEN-1:0] w_tmrRdData;
  logic [XLEN-1:0] w_rdValue;

  assign w_rdRegion = decodeRegion(bus.rd_addr_i);
  assign w_wrRegion = decodeRegion(bus.wr_addr_i);
  assign w_rdActive = bus.rd_en_i && !rst_i;
  assign w_wrActive = bus.wr_en_i && (bus.wr_byte_en_i != 4'b0) && !rst_i;
  assign w_rdIdx    = bus.rd_addr_i[2 +: AW];
  assign w_wrIdx    = bus.wr_addr_i[2 +: AW];

  dram_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_wrEn     (w_wrActive && w_wrRegion == REGION_TIMER),
    .i_wrOff    ({bus.wr_addr_i[3:2], 2'b00}),
    .i_wrData   (bus.wr_data_i),
    .i_wrByteEn (bus.wr_byte_en_i),
    .i_rdOff    ({bus.rd_addr_i[3:2], 2'b00}),
    .o_rdData   (w_tmrRdData),
    .o_irq      (bus.timer_irq_o)
  );

  always_ff @(posedge clk_i) begin
    if (w_wrActive && w_wrRegion == REGION_RAM)
      r_mem[w_wrIdx] <= mergeLanes(r_mem[w_wrIdx], bus.wr_data_i, bus.wr_byte_en_i);
  end

  // RAM reads forward same-word write lanes; timer reads see pre-write values.
  always_comb begin
    w_rdValue = '0;
    case (w_rdRegion)
      REGION_RAM: begin
        if (w_wrActive && w_wrRegion == REGION_RAM && w_wrIdx == w_rdIdx)
          w_rdValue = mergeLanes(r_mem[w_rdIdx], bus.wr_data_i, bus.wr_byte_en_i);
        else
          w_rdValue = r_mem[w_rdIdx];
      end
      REGION_TIMER: w_rdValue = w_tmrRdData;
      default:      w_rdValue = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rdValid <= w_rdActive;
      if (w_rdActive) r_rdData <= w_rdValue;
      r_err <= (w_rdActive && w_rdRegion == REGION_UNMAPPED) ||
               (w_wrActive && w_wrRegion == REGION_UNMAPPED);
    end
  end

  assign bus.rd_data_o  = r_rdData;
  assign bus.rd_valid_o = r_rdValid;
  assign bus.err_o      = r_err;

endmodule

// File: tb/tb_dram_ctl.sv
// Directed bench for dram_ctl: RAM lanes and forwarding, timer carry and
// interrupt, unmapped decode and reset discard.
module tb_dram_ctl;

  localparam logic [31:0] TB = 32'h0200_0000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dram_ctl_if #(.XLEN(32)) bus ();

  dram_ctl #(.XLEN(32), .DEPTH(1024), .TIMER_BASE(32'h0200_0000)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic rdEn, input logic [31:0] rdAddr,
                               input logic wrEn, input logic [31:0] wrAddr,
                               input logic [31:0] wrData, input logic [3:0] be);
    bus.rd_en_i      = rdEn;
    bus.rd_addr_i    = rdAddr;
    bus.wr_en_i      = wrEn;
    bus.wr_addr_i    = wrAddr;
    bus.wr_data_i    = wrData;
    bus.wr_byte_en_i = be;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    rst_i = 1'b1;
    bus.rd_en_i = 1'b0; bus.rd_addr_i = '0; bus.wr_en_i = 1'b0;
    bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.wr_byte_en_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_valid", bus.rd_valid_o, 0);
    checkOutput("reset_err",   bus.err_o, 0);
    checkOutput("reset_irq",   bus.timer_irq_o, 0);
    checkOutput("reset_data",  bus.rd_data_o, 0);
    rst_i = 1'b0;

    // mtime counts from 0 after release; sampled at cycle 5
    repeat (5) idle();
    applyStimulus(1, TB + 32'h0, 0, 0, 0, 4'h0);
    checkOutput("mtime_cycle5", bus.rd_data_o, 5);
    checkOutput("mtime_cycle5_valid", bus.rd_valid_o, 1);

    // carry from low half into high half
    applyStimulus(0, 0, 1, TB + 32'h0, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(0, 0, 1, TB + 32'h4, 32'h0, 4'hF);
    applyStimulus(1, TB + 32'h0, 0, 0, 0, 4'h0);
    checkOutput("mtime_lo_written", bus.rd_data_o, 32'hFFFF_FFFF);
    applyStimulus(1, TB + 32'h4, 0, 0, 0, 4'h0);
    checkOutput("mtime_hi_carry", bus.rd_data_o, 1);

    // read-first on a timer register written in the same cycle
    applyStimulus(1, TB + 32'h8, 1, TB + 32'h8, 32'h55, 4'hF);
    checkOutput("cmp_read_first", bus.rd_data_o, 32'hFFFF_FFFF);
    applyStimulus(1, TB + 32'h8, 0, 0, 0, 4'h0);
    checkOutput("cmp_lo_after", bus.rd_data_o, 32'h55);

    // mtime=10, mtimecmp=20; mtime is 12 once both cmp halves are written
    applyStimulus(0, 0, 1, TB + 32'h4, 32'h0, 4'hF);
    applyStimulus(0, 0, 1, TB + 32'h0, 32'd10, 4'hF);
    applyStimulus(0, 0, 1, TB + 32'h8, 32'd20, 4'hF);
    applyStimulus(0, 0, 1, TB + 32'hC, 32'h0, 4'hF);
    checkOutput("irq_low_12", bus.timer_irq_o, 0);
    repeat (8) idle();
    checkOutput("irq_low_at_20", bus.timer_irq_o, 0);
    idle();
    checkOutput("irq_rise", bus.timer_irq_o, 1);
    applyStimulus(0, 0, 1, TB + 32'hC, 32'hFFFF_FFFF, 4'hF);
    checkOutput("irq_lag", bus.timer_irq_o, 1);
    idle();
    checkOutput("irq_fall", bus.timer_irq_o, 0);

    // RAM full write, read latency and hold
    applyStimulus(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    checkOutput("write_no_valid", bus.rd_valid_o, 0);
    applyStimulus(1, 32'h10, 0, 0, 0, 4'h0);
    checkOutput("ram_read", bus.rd_data_o, 32'hDEAD_BEEF);
    checkOutput("ram_read_valid", bus.rd_valid_o, 1);
    checkOutput("ram_read_noerr", bus.err_o, 0);
    idle();
    checkOutput("idle_valid", bus.rd_valid_o, 0);
    checkOutput("idle_hold", bus.rd_data_o, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 1, 32'h10, 32'h0000_00AA, 4'h1);
    applyStimulus(1, 32'h10, 0, 0, 0, 4'h0);
    checkOutput("ram_lane0", bus.rd_data_o, 32'hDEAD_BEAA);
    applyStimulus(1, 32'h10, 1, 32'h10, 32'h1122_3344, 4'hC);
    checkOutput("ram_forward", bus.rd_data_o, 32'h1122_BEAA);
    applyStimulus(0, 0, 1, 32'h10, 32'h0, 4'h0);
    applyStimulus(0, 0, 1, 32'h14, 32'hCAFE_F00D, 4'hF);
    applyStimulus(0, 0, 1, 32'hFFC, 32'h1234_5678, 4'hF);
    applyStimulus(1, 32'h10, 0, 0, 0, 4'h0);
    checkOutput("ram_be0_noop", bus.rd_data_o, 32'h1122_BEAA);
    applyStimulus(1, 32'h14, 0, 0, 0, 4'h0);
    checkOutput("ram_word5", bus.rd_data_o, 32'hCAFE_F00D);
    applyStimulus(1, 32'hFFC, 0, 0, 0, 4'h0);
    checkOutput("ram_top_word", bus.rd_data_o, 32'h1234_5678);

    // just past the RAM and far away: unmapped
    applyStimulus(1, 32'h1000, 0, 0, 0, 4'h0);
    checkOutput("ram_limit_data", bus.rd_data_o, 0);
    checkOutput("ram_limit_err", bus.err_o, 1);
    applyStimulus(1, 32'h4000_0000, 0, 0, 0, 4'h0);
    checkOutput("unmapped_valid", bus.rd_valid_o, 1);
    checkOutput("unmapped_err", bus.err_o, 1);
    idle();
    checkOutput("unmapped_err_pulse", bus.err_o, 0);
    applyStimulus(1, 32'h4000_0000, 1, 32'h5000_0000, 32'h1, 4'hF);
    checkOutput("both_unmapped_err", bus.err_o, 1);
    idle();
    checkOutput("both_unmapped_single", bus.err_o, 0);
    applyStimulus(0, 0, 1, 32'h5000_0000, 32'h1, 4'h0);
    checkOutput("unmapped_be0_noerr", bus.err_o, 0);

    // requests under reset are discarded
    rst_i = 1'b1;
    applyStimulus(1, 32'h10, 1, 32'h10, 32'h0, 4'hF);
    checkOutput("rst_valid", bus.rd_valid_o, 0);
    checkOutput("rst_err", bus.err_o, 0);
    checkOutput("rst_data", bus.rd_data_o, 0);
    rst_i = 1'b0;
    applyStimulus(1, TB + 32'h0, 0, 0, 0, 4'h0);
    checkOutput("rst_mtime", bus.rd_data_o, 0);
    applyStimulus(1, 32'h10, 0, 0, 0, 4'h0);
    checkOutput("rst_ram_kept", bus.rd_data_o, 32'h1122_BEAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_ctl.md
# dram_ctl

Data-side memory controller sitting directly downstream of the `cpu` data port: it consumes the core's `dram_rd_*` / `dram_wr_*` requests and returns read data. It contains a word-organised data RAM with byte-lane writes and a memory-mapped 64-bit machine timer with compare interrupt. It decodes each access to RAM, timer, or unmapped, and flags unmapped accesses.

## Interface
- `XLEN`, 32: data and address width.
- `DEPTH`, 1024: RAM size in XLEN-bit words; power of two.
- `TIMER_BASE`, 32'h0200_0000: base address of the 16-byte timer window.
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `rd_en_i`  in  1  read request, one per cycle.
- `rd_addr_i`  in  XLEN  read byte address; bits [1:0] ignored.
- `wr_en_i`  in  1  write request.
- `wr_addr_i`  in  XLEN  write byte address; bits [1:0] ignored.
- `wr_data_i`  in  XLEN  write data, lane-aligned.
- `wr_byte_en_i`  in  4  byte-lane write enables; bit n covers `wr_data_i[8n+7:8n]`.
- `rd_data_o`  out  XLEN  registered read data.
- `rd_valid_o`  out  1  high the cycle after an accepted `rd_en_i`.
- `err_o`  out  1  one-cycle pulse, cycle after an unmapped access.
- `timer_irq_o`  out  1  level, `mtime >= mtimecmp`, registered.

## Operation
- Address decode per port, applied to the word address `addr[XLEN-1:2]`:
  - RAM: `addr < DEPTH*4`. Word index is `addr[2 +: log2(DEPTH)]`.
  - TIMER: `addr[XLEN-1:4] == TIMER_BASE[XLEN-1:4]`. Offset 0x0 = mtime_lo, 0x4 = mtime_hi, 0x8 = mtimecmp_lo, 0xC = mtimecmp_hi.
  - Anything else is UNMAPPED.
- Writes:
  - RAM and timer writes honour `wr_byte_en_i` per lane.
  - `wr_byte_en_i == 0` is a no-op and raises no error, even if the address is unmapped.
  - Unmapped writes are dropped.
- Reads:
  - Unmapped reads return 0 and still assert `rd_valid_o`.
  - Timer reads return the register value at the request cycle, before any increment or write in that cycle.
- Timer behaviour:
  - `mtime` increments by 1 every cycle, wrapping at 2^64−1 → 0.
  - A write to either mtime half replaces the increment for that cycle. The written lanes take the new data; the unwritten lanes of that half hold their current value. The other half holds.
  - 64-bit compare is unsigned.
- Simultaneous read and write to the same RAM word are write-first: `rd_data_o` carries written lanes from `wr_data_i` and unwritten lanes from the old word.
- Simultaneous read and write to the same timer register are read-first: the read returns the old value.
- `err_o` pulses once if either port hit UNMAPPED in that cycle; both ports unmapped still gives a single pulse.

## Timing
- Read latency is 1 cycle: request at cycle N, then `rd_data_o` and `rd_valid_o` are valid at N+1.
- Writes take effect at the clock edge ending the request cycle.
- `rd_data_o` holds its last value when `rd_valid_o` is low.
- `timer_irq_o` is updated from the registered `mtime` / `mtimecmp`, so it lags a register change by 1 cycle.
- Reset values (registers loaded on the `rst_i` edge):
  - `rd_data_o` = 0, `rd_valid_o` = 0, `err_o` = 0.
  - `mtime` = 0, `mtimecmp` = all-ones, `timer_irq_o` = 0.
  - RAM contents are not reset.
- A request presented in a cycle with `rst_i` high is discarded: no write, no valid, no error.
- A read outstanding when reset asserts yields no `rd_valid_o`.

## Structure
- Package `dram_pkg` holds:
  - region enum `region_t` {REGION_RAM, REGION_TIMER, REGION_UNMAPPED};
  - timer offset constants `TMR_MTIME_LO/HI`, `TMR_MTIMECMP_LO/HI`;
  - a byte-lane merge function shared by the RAM and timer write paths.
- Sub-module `dram_timer` contains the mtime/mtimecmp registers, lane writes, increment, compare, `timer_irq_o` and the read mux.
- The top level contains the decode, the RAM array with its forwarding path, the read-data register and the error pulse.

## Test plan
- Reset, then write 0xDEADBEEF with byte-en 0xF to 0x10; read 0x10 → `rd_data_o` = 0xDEADBEEF with `rd_valid_o` one cycle after the request; then write 0x000000AA with byte-en 0x1 and read → 0xDEADBEAA.
- Same-cycle write of 0x11223344 with byte-en 0xC and read of that word holding 0xDEADBEAA → `rd_data_o` = 0x1122BEAA.
- Read mtime_lo at cycle 5 after reset release → 5; write mtime_lo = 0xFFFFFFFF and mtime_hi = 0 → two cycles later mtime_hi reads 1 (carry into the high half).
- Write mtimecmp = 20 and mtime = 10 → `timer_irq_o` rises on the cycle after mtime reaches 20; write mtimecmp = all-ones → irq falls 1 cycle later.
- Read 0x4000_0000 → `rd_valid_o` = 1, `rd_data_o` = 0, `err_o` pulses for one cycle. Simultaneous unmapped read and write → a single `err_o` pulse. Unmapped write with byte-en 0 → no `err_o`.
- Assert `rst_i` in the same cycle as a write to 0x10 → the word is unchanged, `rd_valid_o` = 0, and mtime = 0 on release.
